// File: rtl/serial_arith_pkg.sv
// ============================================================================
//  Module      : serial_arith_pkg
//  Description : Shared types and helpers for the bit-serial arithmetic blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Width of a counter that walks bit positions 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/one_bit_full_subtractor.sv
// ============================================================================
//  Module      : one_bit_full_subtractor
//  Description : Gate-level one-bit full subtractor: d = a-b-bin, borrow out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module one_bit_full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    wire w_axb;
    wire w_na;
    wire w_nxb;
    wire w_t1;
    wire w_t2;

    xor u_x1 (w_axb, a, b);
    xor u_x2 (d, w_axb, bin);

    // Borrow when a<b outright, or when a==b and a borrow is already pending.
    not u_n1 (w_na, a);
    and u_a1 (w_t1, w_na, b);
    not u_n2 (w_nxb, w_axb);
    and u_a2 (w_t2, w_nxb, bin);
    or  u_o1 (bout, w_t1, w_t2);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor (a - b), LSB first, one bit per
//                clock through a single full-subtractor cell.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         overflow,
    output logic         zero
);

    localparam int              CW       = cnt_width(N);
    localparam logic [CW-1:0]   LAST_BIT = CW'(N - 1);

    sub_state_t    state_q,      state_d;
    logic [N-1:0]  a_sh_q,       a_sh_d;
    logic [N-1:0]  b_sh_q,       b_sh_d;
    logic [N-1:0]  res_q,        res_d;
    logic          borrow_q,     borrow_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic          borrow_out_q, borrow_out_d;
    logic          overflow_q,   overflow_d;
    logic          zero_q,       zero_d;

    logic w_d;
    logic w_bout;

    one_bit_full_subtractor u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (w_d),
        .bout (w_bout)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        borrow_d     = borrow_q;
        cnt_d        = cnt_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        zero_d       = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = BUSY;
                end
            end

            BUSY: begin
                a_sh_d   = {1'b0, a_sh_q[N-1:1]};
                b_sh_d   = {1'b0, b_sh_q[N-1:1]};
                res_d    = {w_d, res_q[N-1:1]};
                borrow_d = w_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Operand LSBs now hold the original MSBs, so the signed
                    // overflow test needs no separate copy of them.
                    borrow_out_d = w_bout;
                    overflow_d   = (a_sh_q[0] ^ b_sh_q[0]) & (a_sh_q[0] ^ w_d);
                    zero_d       = ~|res_d;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            borrow_q     <= 1'b0;
            cnt_q        <= '0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            borrow_q     <= borrow_d;
            cnt_q        <= cnt_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
            zero_q       <= zero_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = res_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;

endmodule

`default_nettype wire
